// File: rtl/adbg_tap_pkg.sv
// Purpose: shared TAP state encoding, instruction opcodes and IR capture pattern.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adbg_tap_pkg;

  // The classic 1149.1 state numbering is used, so all 16 codes name real states.
  typedef enum logic [3:0] {
    TAP_EXIT2_DR  = 4'h0,
    TAP_EXIT1_DR  = 4'h1,
    TAP_SHIFT_DR  = 4'h2,
    TAP_PAUSE_DR  = 4'h3,
    TAP_SEL_IR    = 4'h4,
    TAP_UPD_DR    = 4'h5,
    TAP_CAP_DR    = 4'h6,
    TAP_SEL_DR    = 4'h7,
    TAP_EXIT2_IR  = 4'h8,
    TAP_EXIT1_IR  = 4'h9,
    TAP_SHIFT_IR  = 4'hA,
    TAP_PAUSE_IR  = 4'hB,
    TAP_RTI       = 4'hC,
    TAP_UPD_IR    = 4'hD,
    TAP_CAP_IR    = 4'hE,
    TAP_TLR       = 4'hF
  } tap_state_t;

  localparam logic [3:0] INSTR_IDCODE = 4'h2;
  localparam logic [3:0] INSTR_DEBUG  = 4'h8;
  localparam logic [3:0] INSTR_BYPASS = 4'hF;

  // Value loaded into the IR shifter in CAP_IR; the two LSBs must read 01.
  localparam logic [3:0] IR_CAPTURE   = 4'b0101;

endpackage

// File: rtl/adbg_tap_ctrl.sv
// Purpose: 1149.1 TAP controller: TMS-driven FSM, IR, IDCODE and BYPASS DRs, TDO mux.
// Latency: strobes decode the state register; BYPASS gives one TCK of TDI->TDO delay.
// Backpressure: none; the JTAG host owns the pace of TCK.
//
// Ports:
//   tck_i, trst_i (sync, active-high), tms_i, tdi_i  - JTAG inputs
//   tdo_o, tdo_oe_o                                   - TDO and its enable (shift states)
//   debug_tdo_i                                       - TDO returned by the debug chain
//   test_logic_reset_o, run_test_idle_o,
//   capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o - TAP state decodes
//   debug_select_o, idcode_select_o, bypass_select_o  - one-hot instruction decode
module adbg_tap_ctrl #(
  parameter int unsigned         IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h149511C3,
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = adbg_tap_pkg::INSTR_IDCODE,
  parameter logic [IR_WIDTH-1:0] INSTR_DEBUG  = adbg_tap_pkg::INSTR_DEBUG,
  parameter logic [IR_WIDTH-1:0] INSTR_BYPASS = adbg_tap_pkg::INSTR_BYPASS
) (
  input  logic tck_i,
  input  logic trst_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tdo_oe_o,
  input  logic debug_tdo_i,
  output logic test_logic_reset_o,
  output logic run_test_idle_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic debug_select_o,
  output logic idcode_select_o,
  output logic bypass_select_o
);
  import adbg_tap_pkg::*;

  tap_state_t          r_state;
  tap_state_t          w_state_nxt;
  logic [IR_WIDTH-1:0] r_ir_shift;
  logic [IR_WIDTH-1:0] r_ir_latched;
  logic [31:0]         r_idcode_sr;
  logic                r_bypass_sr;

  // ---------------- FSM ----------------
  always_ff @(posedge tck_i) begin
    if (trst_i) r_state <= TAP_TLR;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = TAP_TLR;
    case (r_state)
      TAP_TLR:      w_state_nxt = tms_i ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      w_state_nxt = tms_i ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   w_state_nxt = tms_i ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   w_state_nxt = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: w_state_nxt = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: w_state_nxt = tms_i ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: w_state_nxt = tms_i ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: w_state_nxt = tms_i ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   w_state_nxt = tms_i ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   w_state_nxt = tms_i ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   w_state_nxt = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: w_state_nxt = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: w_state_nxt = tms_i ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: w_state_nxt = tms_i ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: w_state_nxt = tms_i ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   w_state_nxt = tms_i ? TAP_SEL_DR   : TAP_RTI;
      default:      w_state_nxt = TAP_TLR;
    endcase
  end

  // ---------------- instruction decode ----------------
  assign debug_select_o  = (r_ir_latched == INSTR_DEBUG);
  assign idcode_select_o = (r_ir_latched == INSTR_IDCODE);
  // BYPASS and every undefined opcode fall through to the 1-bit bypass DR.
  assign bypass_select_o = !debug_select_o && !idcode_select_o;

  // ---------------- shift registers ----------------
  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      r_ir_shift   <= '0;
      r_ir_latched <= INSTR_IDCODE;
      r_idcode_sr  <= '0;
      r_bypass_sr  <= 1'b0;
    end else begin
      case (r_state)
        TAP_CAP_IR:   r_ir_shift <= IR_WIDTH'(IR_CAPTURE);
        TAP_SHIFT_IR: r_ir_shift <= {tdi_i, r_ir_shift[IR_WIDTH-1:1]};
        default:      r_ir_shift <= r_ir_shift;
      endcase

      // Entering (or staying in) TLR through TMS behaves like a reset of the IR.
      if (w_state_nxt == TAP_TLR)     r_ir_latched <= INSTR_IDCODE;
      else if (r_state == TAP_UPD_IR) r_ir_latched <= r_ir_shift;

      if (r_state == TAP_CAP_DR) begin
        r_bypass_sr <= 1'b0;
        if (idcode_select_o) r_idcode_sr <= IDCODE_VALUE;
      end else if (r_state == TAP_SHIFT_DR) begin
        r_bypass_sr <= tdi_i;
        if (idcode_select_o) r_idcode_sr <= {tdi_i, r_idcode_sr[31:1]};
      end
    end
  end

  // ---------------- state strobes ----------------
  assign test_logic_reset_o = (r_state == TAP_TLR);
  assign run_test_idle_o    = (r_state == TAP_RTI);
  assign capture_dr_o       = (r_state == TAP_CAP_DR);
  assign shift_dr_o         = (r_state == TAP_SHIFT_DR);
  assign pause_dr_o         = (r_state == TAP_PAUSE_DR);
  assign update_dr_o        = (r_state == TAP_UPD_DR);
  assign tdo_oe_o           = (r_state == TAP_SHIFT_IR) || (r_state == TAP_SHIFT_DR);

  // ---------------- TDO mux (pad does the falling-edge retime) ----------------
  always_comb begin
    tdo_o = 1'b0;
    if (r_state == TAP_SHIFT_IR) begin
      tdo_o = r_ir_shift[0];
    end else if (r_state == TAP_SHIFT_DR) begin
      if (debug_select_o)       tdo_o = debug_tdo_i;
      else if (idcode_select_o) tdo_o = r_idcode_sr[0];
      else                      tdo_o = r_bypass_sr;
    end
  end

endmodule

// File: tb/tb_adbg_tap_ctrl.sv
// Purpose: self-checking bench for adbg_tap_ctrl against a table-driven TAP model.
// Latency: outputs sampled one time unit after each falling edge, before the next rise.
// Backpressure: n/a.
module tb_adbg_tap_ctrl;

  logic tck_i, trst_i, tms_i, tdi_i, debug_tdo_i;
  logic tdo_o, tdo_oe_o, test_logic_reset_o, run_test_idle_o;
  logic capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o;
  logic debug_select_o, idcode_select_o, bypass_select_o;

  adbg_tap_ctrl dut (
    .tck_i              (tck_i),
    .trst_i             (trst_i),
    .tms_i              (tms_i),
    .tdi_i              (tdi_i),
    .tdo_o              (tdo_o),
    .tdo_oe_o           (tdo_oe_o),
    .debug_tdo_i        (debug_tdo_i),
    .test_logic_reset_o (test_logic_reset_o),
    .run_test_idle_o    (run_test_idle_o),
    .capture_dr_o       (capture_dr_o),
    .shift_dr_o         (shift_dr_o),
    .pause_dr_o         (pause_dr_o),
    .update_dr_o        (update_dr_o),
    .debug_select_o     (debug_select_o),
    .idcode_select_o    (idcode_select_o),
    .bypass_select_o    (bypass_select_o)
  );

  initial tck_i = 1'b0;
  always #5 tck_i = ~tck_i;

  // Model state numbering (bench-local):
  // 0 TLR 1 RTI 2 SEL_DR 3 CAP_DR 4 SHIFT_DR 5 EXIT1_DR 6 PAUSE_DR 7 EXIT2_DR 8 UPD_DR
  // 9 SEL_IR 10 CAP_IR 11 SHIFT_IR 12 EXIT1_IR 13 PAUSE_IR 14 EXIT2_IR 15 UPD_IR
  int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2,  0, 12, 12, 15, 14, 15, 2};

  localparam logic [31:0] IDC = 32'h149511C3;

  int          m_st;
  logic [3:0]  m_ir_sh, m_ir_lat;
  logic [31:0] m_id;
  logic        m_byp;
  logic        m_dtdo;
  bit          m_valid;

  logic last_tdo, last_oe, last_dt, last_shdr;

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic e_tdo;
    e_tdo = 1'b0;
    if (m_st == 11) e_tdo = m_ir_sh[0];
    else if (m_st == 4) begin
      if (m_ir_lat == 4'h8)      e_tdo = m_dtdo;
      else if (m_ir_lat == 4'h2) e_tdo = m_id[0];
      else                       e_tdo = m_byp;
    end
    check_eq("m_tdo",    tdo_o,              e_tdo);
    check_eq("m_oe",     tdo_oe_o,           (m_st == 4 || m_st == 11));
    check_eq("m_tlr",    test_logic_reset_o, (m_st == 0));
    check_eq("m_rti",    run_test_idle_o,    (m_st == 1));
    check_eq("m_capdr",  capture_dr_o,       (m_st == 3));
    check_eq("m_shdr",   shift_dr_o,         (m_st == 4));
    check_eq("m_psdr",   pause_dr_o,         (m_st == 6));
    check_eq("m_updr",   update_dr_o,        (m_st == 8));
    check_eq("m_dbgsel", debug_select_o,     (m_ir_lat == 4'h8));
    check_eq("m_idsel",  idcode_select_o,    (m_ir_lat == 4'h2));
    check_eq("m_bypsel", bypass_select_o,    (m_ir_lat != 4'h8 && m_ir_lat != 4'h2));
  endtask

  task automatic model_step(input logic tms, input logic tdi, input logic trst);
    int nst;
    if (trst) begin
      m_st = 0; m_ir_lat = 4'h2; m_ir_sh = 4'h0; m_id = 32'h0; m_byp = 1'b0;
      m_valid = 1'b1;
      return;
    end
    case (m_st)
      10: m_ir_sh = 4'b0101;
      11: m_ir_sh = (m_ir_sh >> 1) | (4'(tdi) << 3);
      3: begin
        m_byp = 1'b0;
        if (m_ir_lat == 4'h2) m_id = IDC;
      end
      4: begin
        m_byp = tdi;
        if (m_ir_lat == 4'h2) m_id = (m_id >> 1) | (32'(tdi) << 31);
      end
      15: m_ir_lat = m_ir_sh;
      default: ;
    endcase
    nst = tms ? nx1[m_st] : nx0[m_st];
    if (nst == 0) m_ir_lat = 4'h2;
    m_st = nst;
  endtask

  // One TCK: drive, compare against the model, clock, advance the model.
  task automatic cycle(input logic tms, input logic tdi, input logic trst);
    m_dtdo = 1'($urandom_range(0, 1));
    tms_i = tms; tdi_i = tdi; trst_i = trst; debug_tdo_i = m_dtdo;
    #1;
    if (m_valid) compare_all();
    last_tdo = tdo_o; last_oe = tdo_oe_o; last_dt = m_dtdo; last_shdr = shift_dr_o;
    @(posedge tck_i);
    model_step(tms, tdi, trst);
    @(negedge tck_i);
    #1;
  endtask

  // From RTI: shift op into the IR, finish in RTI; cap returns the captured bits.
  task automatic load_ir(input logic [3:0] op, output logic [3:0] cap);
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(i == 3, op[i], 0);
      cap[i] = last_tdo;
    end
    cycle(1, 0, 0); cycle(0, 0, 0);
  endtask

  initial begin
    logic [31:0] word;
    logic [3:0]  cap;
    logic [4:0]  pat, got;
    n_checks = 0; n_fail = 0; m_valid = 1'b0;
    tms_i = 1'b1; tdi_i = 1'b0; trst_i = 1'b1; debug_tdo_i = 1'b0;
    @(negedge tck_i);

    // Reset
    cycle(0, 0, 1);
    check_eq("rst_tlr",   test_logic_reset_o, 1);
    check_eq("rst_idsel", idcode_select_o, 1);
    check_eq("rst_oe",    tdo_oe_o, 0);
    check_eq("rst_tdo",   tdo_o, 0);
    check_eq("rst_dbg",   debug_select_o, 0);
    check_eq("rst_strb",  {capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o, run_test_idle_o}, 0);

    // IDCODE read
    cycle(0, 0, 0); cycle(1, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      cycle(i == 31, 1'($urandom_range(0, 1)), 0);
      word[i] = last_tdo;
      check_eq("id_oe", last_oe, 1);
    end
    check_eq("id_word", word, 32'h149511C3);
    cycle(1, 0, 0); cycle(0, 0, 0);

    // Load DEBUG, then shift the debug chain
    load_ir(4'h8, cap);
    check_eq("ir_cap",     cap, 4'b0101);
    check_eq("dbg_sel",    debug_select_o, 1);
    check_eq("dbg_idsel",  idcode_select_o, 0);
    cycle(1, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(i == 5, 1'($urandom_range(0, 1)), 0);
      check_eq("dbg_tdo",  last_tdo, last_dt);
      check_eq("dbg_shdr", last_shdr, 1);
    end
    cycle(1, 0, 0);
    check_eq("dbg_updr", update_dr_o, 1);
    cycle(0, 0, 0);

    // BYPASS and an undefined opcode
    load_ir(4'hF, cap);
    check_eq("byp_sel_f", bypass_select_o, 1);
    cycle(1, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    pat = 5'b01011;
    for (int i = 0; i < 5; i++) begin
      cycle(i == 4, pat[i], 0);
      got[i] = last_tdo;
    end
    check_eq("byp_delay", got, 5'b10110);
    cycle(1, 0, 0); cycle(0, 0, 0);
    load_ir(4'h5, cap);
    check_eq("byp_sel_5", bypass_select_o, 1);
    check_eq("byp_idsel_5", idcode_select_o, 0);

    // IR shift interrupted by a 3-clock pause
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(0, 0, 0); cycle(1, 0, 0);
    cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0); cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0); cycle(1, 1, 0);
    cycle(1, 0, 0); cycle(0, 0, 0);
    check_eq("pause_dbg", debug_select_o, 1);

    // TMS escape from PAUSE_IR
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(1, 0, 0); cycle(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0);
      check_eq("esc_not_tlr", test_logic_reset_o, 0);
    end
    cycle(1, 0, 0);
    check_eq("esc_tlr",   test_logic_reset_o, 1);
    check_eq("esc_idsel", idcode_select_o, 1);

    // Reset in the middle of an IR shift
    cycle(0, 0, 0);
    load_ir(4'h8, cap);
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(0, 1, 0); cycle(0, 1, 0);
    cycle(1, 1, 1);
    check_eq("mid_tlr",   test_logic_reset_o, 1);
    check_eq("mid_idsel", idcode_select_o, 1);
    check_eq("mid_updr",  update_dr_o, 0);

    // Randomized traffic checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adbg_tap_ctrl.md
Name: adbg_tap_ctrl

Overview:
- IEEE 1149.1 TAP controller that sits directly upstream of the debug top level.
- Decodes TMS into the 16-state TAP FSM, holds the instruction register, and implements the IDCODE and BYPASS data registers.
- Drives the TAP-state strobes (shift/pause/update/capture DR) and debug_select consumed by the debug top.
- Multiplexes TDO between its own registers and the debug top's returned TDO.

Parameters:
- IR_WIDTH, 4, instruction register width.
- IDCODE_VALUE, 32'h149511C3, value captured into the IDCODE DR; bit 0 must be 1.
- INSTR_IDCODE, 4'h2, IDCODE opcode, loaded on reset.
- INSTR_DEBUG, 4'h8, opcode selecting the debug chain.
- INSTR_BYPASS, 4'hF, BYPASS opcode.

Ports:
- tck_i  in  1  JTAG clock; the only clock; all state on posedge.
- trst_i  in  1  reset, synchronous, active-high.
- tms_i  in  1  test mode select.
- tdi_i  in  1  test data in.
- tdo_o  out  1  test data out (combinational mux of registered sources).
- tdo_oe_o  out  1  TDO enable; high in SHIFT_IR or SHIFT_DR.
- debug_tdo_i  in  1  TDO returned from the debug top.
- test_logic_reset_o  out  1  state == TEST_LOGIC_RESET.
- run_test_idle_o  out  1  state == RUN_TEST_IDLE.
- capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o  out  1 each  decode of the matching DR state.
- debug_select_o  out  1  latched IR == INSTR_DEBUG.
- idcode_select_o  out  1  latched IR == INSTR_IDCODE.
- bypass_select_o  out  1  IR decodes to bypass (BYPASS or any undefined opcode).

Behaviour:
- Clock and reset: one clock, tck_i. Reset trst_i is synchronous and active-high. On trst_i, all of the following happen at the next posedge:
  - state <= TEST_LOGIC_RESET
  - ir_latched <= INSTR_IDCODE
  - ir_shift <= 0
  - idcode_sr <= 0
  - bypass_sr <= 0
- Outputs after reset:
  - test_logic_reset_o = 1 and idcode_select_o = 1.
  - All other strobes, debug_select_o and tdo_oe_o = 0.
  - tdo_o = 0.
- FSM, standard 1149.1 transitions on tms_i at each posedge, written as "tms=0 / tms=1":
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - CAP_DR: SHIFT_DR / EXIT1_DR
  - SHIFT_DR: SHIFT_DR / EXIT1_DR
  - EXIT1_DR: PAUSE_DR / UPD_DR
  - PAUSE_DR: PAUSE_DR / EXIT2_DR
  - EXIT2_DR: SHIFT_DR / UPD_DR
  - UPD_DR: RTI / SEL_DR
  - SEL_IR: CAP_IR / TLR
  - IR-side states mirror the DR side exactly; UPD_IR goes to RTI / SEL_DR.
- Five consecutive tms=1 clocks reach TLR from any state.
- State strobes are pure decodes of the state register, so the downstream block samples shift_dr_o at the same posedge that advances the state.
- Any illegal state encoding returns to TLR on the next clock.
- TLR entry by TMS loads ir_latched <= INSTR_IDCODE at the same time as the state change, identical to reset.
- IR path:
  - CAP_IR: ir_shift <= 4'b0101 (LSBs 01 as required by 1149.1).
  - SHIFT_IR: ir_shift <= {tdi_i, ir_shift[IR_WIDTH-1:1]}, LSB first.
  - UPD_IR: ir_latched <= ir_shift.
  - ir_latched changes only in UPD_IR or TLR. A pause mid-shift preserves ir_shift.
- IDCODE DR:
  - CAP_DR with idcode_select: load IDCODE_VALUE.
  - SHIFT_DR with idcode_select: shift right, tdi_i into the MSB.
- BYPASS DR:
  - CAP_DR: bypass_sr <= 0.
  - SHIFT_DR: bypass_sr <= tdi_i. This gives exactly one clock of TDI->TDO delay.
- TDO mux:
  - SHIFT_IR: ir_shift[0].
  - SHIFT_DR with debug_select: debug_tdo_i.
  - SHIFT_DR with idcode_select: idcode_sr[0].
  - SHIFT_DR with bypass_select: bypass_sr.
  - Otherwise: 0.
  - Falling-edge retiming of TDO is done at the pad and is outside this block.
- Selects are mutually exclusive. Opcodes other than IDCODE and DEBUG assert bypass_select_o (EXTEST and SAMPLE are not implemented).
- Reset mid-shift: the current shift is abandoned, the IR returns to IDCODE, and no update strobe is issued.

Decomposition:
- Package adbg_tap_pkg holds:
  - the tap_state_t enum (16 states, 4-bit encoding)
  - the INSTR_* opcode constants
  - the IR capture pattern constant
- Single module; no sub-module is warranted (FSM plus three small shift registers).

Test Plan:
- Reset: trst_i=1 for 1 clk -> test_logic_reset_o=1, idcode_select_o=1, tdo_oe_o=0, all DR strobes 0.
- TMS escape: drive the FSM to PAUSE_IR, then tms=1 for 5 clks -> TLR on the 5th clk and ir_latched=4'h2; fewer than 5 clks -> not in TLR.
- IDCODE read: TLR->RTI->SEL_DR->CAP_DR->SHIFT_DR, then 32 shifts -> tdo_o stream LSB first equals 32'h149511C3; tdo_oe_o=1 throughout the shift.
- IR load DEBUG: shift 4'h8 LSB first -> tdo_o returns 1,0,1,0 (capture 0101); after UPD_IR, debug_select_o=1 and idcode_select_o=0; in SHIFT_DR, tdo_o follows debug_tdo_i and shift_dr_o/update_dr_o pulse in SHIFT_DR/UPD_DR.
- BYPASS/undefined: load 4'hF, then 4'h5 -> bypass_select_o=1 for both; tdi pattern 1101 emerges on tdo_o delayed by exactly 1 clk, with the first bit 0.
- Pause and reset mid-op: shift 2 IR bits, go to PAUSE_IR for 3 clks, resume and finish -> correct opcode latched; repeat with trst_i=1 mid-shift -> TLR, IR=IDCODE, no update_dr_o or UPD_IR seen.
